// File: rtl/umi_fifo_arb.sv
`default_nettype none
// ============================================================================
//  Module   : umi_fifo_arb
//  Purpose  : N-channel UMI request concentrator. Round-robin arbitration of
//             N UMI input ports into one single-clock FIFO. Arbitration locks
//             to one channel for the whole of a multi-beat message (EOM=cmd[22]).
//             The FIFO drives one UMI output port and reports occupancy,
//             full, empty and almost-full status.
//  Ports    : clk, nreset (async, active-low), chaosmode (throttles valid)
//             umi_in_*   : N packed input channels, channel i at [i*W +: W]
//             umi_in_ready : one-hot or zero
//             umi_out_*  : FIFO head entry, valid/ready handshake
//             fifo_level/full/empty/afull : registered occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module umi_fifo_arb #(
  parameter int N     = 4,
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 128,
  parameter int DEPTH = 8,
  parameter int AFULL = 6,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            chaosmode,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic [LW-1:0]   fifo_level,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            fifo_afull
);

  localparam int c_pw      = $clog2(N);
  localparam int c_aw      = $clog2(DEPTH);
  localparam int c_ew      = CW + 2*AW + DW;
  localparam int c_eom_bit = 22;
  localparam logic [LW-1:0] c_depth     = LW'(DEPTH);
  localparam logic [LW-1:0] c_afull     = LW'(AFULL);
  localparam logic [15:0]   c_lfsr_seed = 16'hACE1;

  // Arbitration state
  logic [c_pw-1:0] r_ptr;
  logic [c_pw-1:0] r_lock_ch;
  logic            r_locked;
  logic [c_pw-1:0] w_gnt_idx;
  logic            w_gnt_vld;

  // FIFO state
  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   w_level_nxt;
  logic            r_full;
  logic            r_empty;
  logic            r_afull;
  logic [15:0]     r_lfsr;

  logic            w_push;
  logic            w_pop;
  logic [c_ew-1:0] w_wr_entry;
  logic            w_wr_eom;
  logic [N-1:0]    w_in_ready;
  logic            w_out_valid;

  // Channel index base+off modulo N (off < N, so one correction suffices).
  function automatic logic [c_pw-1:0] f_rr_idx(input logic [c_pw-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return s[c_pw-1:0];
  endfunction

  // Grant: locked channel only, else first valid channel from r_ptr onward.
  // The unlocked search runs from the far end so the nearest hit wins.
  always_comb begin
    w_gnt_idx = r_ptr;
    w_gnt_vld = 1'b0;
    if (r_locked) begin
      w_gnt_idx = r_lock_ch;
      w_gnt_vld = umi_in_valid[r_lock_ch];
    end else begin
      for (int k = N-1; k >= 0; k--) begin
        if (umi_in_valid[f_rr_idx(r_ptr, k)]) begin
          w_gnt_idx = f_rr_idx(r_ptr, k);
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  // A full FIFO refuses writes even when a pop happens in the same cycle.
  // nreset gates ready so it reads zero for the whole reset window.
  assign w_push = w_gnt_vld & ~r_full & nreset;

  always_comb begin
    w_in_ready = '0;
    w_wr_entry = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(w_gnt_idx) == i) begin
        w_in_ready[i] = w_push;
        w_wr_entry = {umi_in_cmd[i*CW +: CW], umi_in_dstaddr[i*AW +: AW],
                      umi_in_srcaddr[i*AW +: AW], umi_in_data[i*DW +: DW]};
      end
    end
  end

  assign w_wr_eom     = w_wr_entry[c_ew-CW+c_eom_bit];
  assign umi_in_ready = w_in_ready;

  assign w_out_valid   = ~r_empty & (~chaosmode | r_lfsr[0]);
  assign umi_out_valid = w_out_valid;
  assign w_pop         = w_out_valid & umi_out_ready;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop)
      w_level_nxt = r_level - LW'(1);
  end

  // Arbitration pointer and message lock
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr     <= '0;
      r_lock_ch <= '0;
      r_locked  <= 1'b0;
    end else if (w_push) begin
      if (w_wr_eom) begin
        r_locked <= 1'b0;
        r_ptr    <= f_rr_idx(w_gnt_idx, 1);
      end else begin
        r_locked  <= 1'b1;
        r_lock_ch <= w_gnt_idx;
      end
    end
  end

  // FIFO storage, pointers and registered status
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wr_entry;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == c_depth);
      r_empty <= (w_level_nxt == '0);
      r_afull <= (w_level_nxt >= c_afull);
    end
  end

  // Fibonacci LFSR, taps 16,14,13,11; free-running, bit 0 throttles valid.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      r_lfsr <= c_lfsr_seed;
    else
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  // Head entry shown directly; it only moves on a pop, so it is stable under backpressure.
  assign umi_out_cmd     = r_mem[r_rd_ptr][c_ew-1 -: CW];
  assign umi_out_dstaddr = r_mem[r_rd_ptr][c_ew-CW-1 -: AW];
  assign umi_out_srcaddr = r_mem[r_rd_ptr][AW+DW-1 -: AW];
  assign umi_out_data    = r_mem[r_rd_ptr][DW-1:0];

  assign fifo_level = r_level;
  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign fifo_afull = r_afull;

endmodule
`default_nettype wire

// File: tb/tb_umi_fifo_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_umi_fifo_arb
//  Purpose  : Self-checking bench for umi_fifo_arb. A queue-based model of the
//             arbiter and FIFO predicts every output each cycle; literal
//             sequences pin the directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_umi_fifo_arb;
  localparam int N = 4, CW = 32, AW = 64, DW = 128, DEPTH = 8, AFULL = 6;
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = CW + 2*AW + DW;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            chaosmode = 1'b0;
  logic [N-1:0]    umi_in_valid = '0;
  logic [N*CW-1:0] umi_in_cmd = '0;
  logic [N*AW-1:0] umi_in_dstaddr = '0;
  logic [N*AW-1:0] umi_in_srcaddr = '0;
  logic [N*DW-1:0] umi_in_data = '0;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready = 1'b0;
  logic [LW-1:0]   fifo_level;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_afull;

  always #5 clk = ~clk;

  umi_fifo_arb #(.N(N), .CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .nreset(nreset), .chaosmode(chaosmode),
    .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
    .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
    .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
    .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
    .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
    .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready),
    .fifo_level(fifo_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_afull(fifo_afull)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [EW-1:0] mq[$];
  bit            m_locked;
  int            m_lock_ch;
  int            m_ptr;
  int            m_lfsr;

  // Traffic generator state and knobs
  logic [EW-1:0] ch_beat [N];
  int ch_rem [N];
  int ch_bi [N];
  int ch_seq [N];
  int ch_first_len [N];
  logic [N-1:0] chmask;
  int p_valid, p_ready, max_len, limit, accepted, gaps;
  logic [31:0] outlog[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] make_beat(int ch, int seq, int beat, bit eom);
    logic [CW-1:0] c;
    logic [AW-1:0] d, s;
    logic [DW-1:0] dat;
    c = $urandom;
    c[22] = eom;
    d = {$urandom, $urandom};
    s = {$urandom, $urandom};
    dat = {$urandom, $urandom, $urandom, $urandom};
    dat[31:0] = 32'((ch << 8) | ((seq % 16) << 4) | (beat % 16));
    return {c, d, s, dat};
  endfunction

  task automatic start_msg(input int ch);
    int len;
    len = (ch_first_len[ch] > 0) ? ch_first_len[ch] : int'($urandom_range(1, max_len));
    ch_first_len[ch] = 0;
    ch_rem[ch] = len;
    ch_bi[ch] = 0;
    ch_beat[ch] = make_beat(ch, ch_seq[ch], 0, len == 1);
  endtask

  task automatic init_gen();
    for (int i = 0; i < N; i++) begin
      ch_seq[i] = 0;
      start_msg(i);
    end
  endtask

  task automatic advance(input int ch);
    ch_rem[ch]--;
    if (ch_rem[ch] == 0) begin
      ch_seq[ch]++;
      start_msg(ch);
    end else begin
      ch_bi[ch]++;
      ch_beat[ch] = make_beat(ch, ch_seq[ch], ch_bi[ch], ch_rem[ch] == 1);
    end
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, update model at posedge.
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    int g, fb;
    bit rdy, ov;
    for (int i = 0; i < N; i++) begin
      v[i] = chmask[i] && (accepted < limit) && ($urandom_range(0, 99) < p_valid);
      umi_in_cmd[i*CW +: CW]     = ch_beat[i][EW-1 -: CW];
      umi_in_dstaddr[i*AW +: AW] = ch_beat[i][EW-CW-1 -: AW];
      umi_in_srcaddr[i*AW +: AW] = ch_beat[i][AW+DW-1 -: AW];
      umi_in_data[i*DW +: DW]    = ch_beat[i][DW-1:0];
    end
    umi_in_valid  = v;
    umi_out_ready = ($urandom_range(0, 99) < p_ready);
    #1;
    g = -1;
    if (m_locked) begin
      if (v[m_lock_ch]) g = m_lock_ch;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    rdy = (g >= 0) && (mq.size() < DEPTH);
    exp_rdy = '0;
    if (rdy) exp_rdy[g] = 1'b1;
    ov = (mq.size() > 0) && (!chaosmode || (m_lfsr % 2 == 1));
    chk("in_ready", 128'(umi_in_ready), 128'(exp_rdy));
    chk("out_valid", 128'(umi_out_valid), 128'(ov));
    if (ov) begin
      chk("out_cmd", 128'(umi_out_cmd), 128'(mq[0][EW-1 -: CW]));
      chk("out_dst", 128'(umi_out_dstaddr), 128'(mq[0][EW-CW-1 -: AW]));
      chk("out_src", 128'(umi_out_srcaddr), 128'(mq[0][AW+DW-1 -: AW]));
      chk("out_data", 128'(umi_out_data), 128'(mq[0][DW-1:0]));
    end
    chk("level", 128'(fifo_level), 128'(mq.size()));
    chk("full", 128'(fifo_full), 128'(mq.size() == DEPTH));
    chk("empty", 128'(fifo_empty), 128'(mq.size() == 0));
    chk("afull", 128'(fifo_afull), 128'(mq.size() >= AFULL));
    if (umi_out_valid && umi_out_ready) outlog.push_back(umi_out_data[31:0]);
    if (mq.size() > 0 && !umi_out_valid) gaps++;
    @(posedge clk);
    if (ov && umi_out_ready) void'(mq.pop_front());
    if (rdy) begin
      mq.push_back(ch_beat[g]);
      if (ch_beat[g][EW-CW+22]) begin
        m_locked = 1'b0;
        m_ptr = (g + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_lock_ch = g;
      end
      accepted++;
      advance(g);
    end
    fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (fb << 15);
    @(negedge clk);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    #2 nreset = 1'b0;
    #1;
    chk("rst_out_valid", 128'(umi_out_valid), 128'(0));
    chk("rst_in_ready", 128'(umi_in_ready), 128'(0));
    chk("rst_level", 128'(fifo_level), 128'(0));
    chk("rst_empty", 128'(fifo_empty), 128'(1));
    chk("rst_full", 128'(fifo_full), 128'(0));
    chk("rst_afull", 128'(fifo_afull), 128'(0));
    chk("rst_out_data", 128'(umi_out_data), 128'(0));
    mq.delete();
    outlog.delete();
    m_locked = 1'b0;
    m_lock_ch = 0;
    m_ptr = 0;
    m_lfsr = 16'hACE1;
    accepted = 0;
    gaps = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp2 [8];
    logic [31:0] exp3 [6];
    int n;
    exp2 = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h010, 32'h110, 32'h210, 32'h310};
    exp3 = '{32'h000, 32'h100, 32'h200, 32'h201, 32'h202, 32'h300};
    for (int i = 0; i < N; i++) ch_first_len[i] = 0;
    chmask = '0; p_valid = 0; p_ready = 0; max_len = 1; limit = 1000000;
    accepted = 0; gaps = 0;
    init_gen();
    @(negedge clk);

    // 1: reset with no stimulus
    do_reset();
    step();

    // 2: all channels single-beat, round-robin order
    do_reset();
    chmask = '1; p_valid = 100; p_ready = 100; max_len = 1;
    init_gen();
    for (int i = 0; i < 12; i++) step();
    chk("rr_count", 128'(outlog.size() >= 8), 128'(1));
    if (outlog.size() >= 8)
      for (int i = 0; i < 8; i++) chk("rr_order", 128'(outlog[i]), 128'(exp2[i]));

    // 3: channel 2 three-beat message is not interleaved
    do_reset();
    ch_first_len[2] = 3;
    init_gen();
    for (int i = 0; i < 10; i++) step();
    chk("lock_count", 128'(outlog.size() >= 6), 128'(1));
    if (outlog.size() >= 6)
      for (int i = 0; i < 6; i++) chk("lock_order", 128'(outlog[i]), 128'(exp3[i]));

    // 4: fill with output stalled
    do_reset();
    chmask = 4'b0001; p_ready = 0;
    init_gen();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("fill_level", 128'(fifo_level), 128'(i));
      chk("fill_afull", 128'(fifo_afull), 128'(i >= 6));
      chk("fill_full", 128'(fifo_full), 128'(i == 8));
    end
    step();
    chk("full_hold_level", 128'(fifo_level), 128'(8));
    chk("full_in_ready", 128'(umi_in_ready), 128'(0));

    // 5: push and pop together while full -> push refused
    p_ready = 100;
    step();
    chk("full_pushpop_level", 128'(fifo_level), 128'(7));
    chmask = '0;
    n = 0;
    while (fifo_level != 0 && n < 40) begin step(); n++; end
    chk("drain_level", 128'(fifo_level), 128'(0));
    chk("drain_count", 128'(outlog.size()), 128'(8));
    if (outlog.size() == 8)
      for (int i = 0; i < 8; i++) chk("drain_order", 128'(outlog[i]), 128'(32'(i << 4)));

    // 6: chaos mode, 100 single-beat messages
    do_reset();
    chaosmode = 1'b1; chmask = '1; p_valid = 60; p_ready = 80; max_len = 1; limit = 100;
    init_gen();
    n = 0;
    while (outlog.size() < 100 && n < 3000) begin step(); n++; end
    chk("chaos_delivered", 128'(outlog.size()), 128'(100));
    chk("chaos_accepted", 128'(accepted), 128'(100));
    chk("chaos_gap_seen", 128'(gaps > 0), 128'(1));

    // Random multi-beat traffic with mixed chaos mode
    limit = 1000000; max_len = 4; p_valid = 70; p_ready = 60;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) chaosmode = $urandom_range(0, 1);
      step();
    end
    chaosmode = 1'b0;

    // Reset mid-message: lock must be dropped
    do_reset();
    chmask = 4'b0010; p_valid = 100; p_ready = 0; max_len = 1;
    ch_first_len[1] = 3;
    init_gen();
    step();
    step();
    chk("mid_level", 128'(fifo_level), 128'(2));
    do_reset();
    chmask = 4'b0011; p_ready = 100;
    init_gen();
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_count", 128'(outlog.size() >= 1), 128'(1));
    if (outlog.size() >= 1) chk("post_rst_first", 128'(outlog[0]), 128'(32'h000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/umi_fifo_arb.md
Name: umi_fifo_arb

Overview:
N-channel UMI request concentrator. Round-robin arbitrates N independent UMI input ports into one shared, single-clock FIFO. Drives a single UMI output port with occupancy and almost-full status. Sits between several host-side UMI agents and one device port such as a memory agent. It generalises the single-channel UMI FIFO to N channels, adds message-locked arbitration, a programmable almost-full threshold and an occupancy count.

Parameters:
N, 4, number of input channels (>=2)
CW, 32, UMI command width
AW, 64, UMI address width
DW, 128, UMI data width
DEPTH, 8, FIFO entries (power of 2, >=2)
AFULL, 6, fifo_afull asserts when fifo_level >= AFULL (1..DEPTH)
LW, $clog2(DEPTH+1), fifo_level width

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
chaosmode  input  1  randomly throttle umi_out_valid
umi_in_valid  input  N  per-channel valid
umi_in_cmd  input  N*CW  channel i at [i*CW +: CW]
umi_in_dstaddr  input  N*AW  per-channel destination address
umi_in_srcaddr  input  N*AW  per-channel source address
umi_in_data  input  N*DW  per-channel data
umi_in_ready  output  N  per-channel ready, one-hot or zero
umi_out_valid  output  1  output valid
umi_out_cmd  output  CW  output command
umi_out_dstaddr  output  AW  output destination address
umi_out_srcaddr  output  AW  output source address
umi_out_data  output  DW  output data
umi_out_ready  input  1  output ready
fifo_level  output  LW  entries held, 0..DEPTH
fifo_full  output  1  level==DEPTH
fifo_empty  output  1  level==0
fifo_afull  output  1  level>=AFULL

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (nreset).
- Reset values:
  - umi_out_valid=0, umi_in_ready=0, fifo_level=0, fifo_empty=1, fifo_full=0, fifo_afull=0.
  - Priority pointer=0, lock cleared, LFSR=16'hACE1.
  - Output payload registers are 0.
- Transfer rule: a transfer happens on a channel when valid&ready is high at a rising clk edge.
  - Ready may depend on valid.
  - Valid never depends on ready.
- Grant, combinational:
  - If locked, grant = locked channel when that channel's valid is high, else no grant.
  - If unlocked, grant = first channel with valid=1 searching ptr, ptr+1, ... mod N.
  - umi_in_ready[i] = grant[i] & !fifo_full.
  - No write when full, even if a pop occurs in the same cycle.
- Lock: EOM is cmd bit 22.
  - Accepting a beat with EOM=0 locks arbitration to that channel.
  - Accepting a beat with EOM=1 clears the lock and sets ptr = (channel+1) mod N.
  - Beats of one message are never interleaved with beats of another channel.
- FIFO:
  - Write stores {cmd,dstaddr,srcaddr,data} of the granted channel.
  - Data is visible at the output the cycle after the write (1-cycle latency).
  - Pop happens when umi_out_valid & umi_out_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - Status outputs are registered and consistent with fifo_level.
- Output:
  - umi_out_* shows the head entry.
  - umi_out_valid = !fifo_empty & (chaosmode ? lfsr[0] : 1).
  - Payload is held stable while valid=1 and ready=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle regardless of chaosmode.
  - When chaosmode=0, umi_out_valid is never masked.
- Reset asserted mid-message: everything returns to reset values immediately. Stored entries are discarded and the lock is cleared.
- A channel dropping valid mid-message keeps the lock; other channels stall.

Test Plan:
1. Reset, no stimulus -> fifo_empty=1, umi_out_valid=0, umi_in_ready=0, fifo_level=0.
2. All 4 channels valid, single-beat (EOM=1) messages with data=channel index, umi_out_ready=1 -> output order 0,1,2,3,0,1...; each umi_out_valid rises 1 cycle after its accept.
3. Channel 2 sends a 3-beat message (EOM=0,0,1) while channels 0,1,3 stay valid -> three contiguous ch2 beats at the output, then ch3 next.
4. umi_out_ready=0, ch0 sends 8 beats -> level counts 1..8; fifo_afull at level 6; fifo_full at 8; umi_in_ready[0]=0 while full. Then ready=1 -> 8 beats drain in order and level returns to 0.
5. Level=8 with one push and one pop in the same cycle -> push refused, level=7.
6. chaosmode=1, 100 single-beat messages -> all 100 delivered intact and in order; umi_out_valid sometimes low while the FIFO is non-empty. Assert nreset mid-message -> outputs return to reset values within the same cycle.
